// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for imm_gen_pipe: input instruction side and output immediate side.
// Optional imm_err signal exists only when IMM_GEN_ERR_FLAG_EN is defined.
interface imm_gen_pipe_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic [2:0]      imm_src;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] imm_ext;
  logic [2:0]      out_fmt;
`ifdef IMM_GEN_ERR_FLAG_EN
  logic            imm_err;
`endif

  modport master (
    output in_valid, instr, imm_src, out_ready,
`ifdef IMM_GEN_ERR_FLAG_EN
    input  imm_err,
`endif
    input  in_ready, out_valid, imm_ext, out_fmt
  );

  modport slave (
    input  in_valid, instr, imm_src, out_ready,
`ifdef IMM_GEN_ERR_FLAG_EN
    output imm_err,
`endif
    output in_ready, out_valid, imm_ext, out_fmt
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Registered RV immediate extender (I/S/B/U/J) with a 2-entry output/skid buffer.
// Optional macro IMM_GEN_ERR_FLAG_EN adds imm_err for undefined format codes 110/111.
module imm_gen_pipe #(
  parameter int XLEN = 32
) (
  input logic           clk,
  input logic           reset,
  imm_gen_pipe_if.slave bus
);
  logic [31:0]     ins;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_new;
  logic            in_fire;
  logic            out_fire;

  logic            or_valid;
  logic [XLEN-1:0] or_imm;
  logic [2:0]      or_fmt;
  logic            sk_valid;
  logic [XLEN-1:0] sk_imm;
  logic [2:0]      sk_fmt;
`ifdef IMM_GEN_ERR_FLAG_EN
  logic            err_new;
  logic            or_err;
  logic            sk_err;
`endif

  assign ins = bus.instr;

  // Every format fits in 32 bits; widen afterwards so U sign-extends from bit 31 at XLEN=64.
  always_comb begin
    imm32 = '0;
    case (bus.imm_src)
      3'b000:  imm32 = {{20{ins[31]}}, ins[31:20]};
      3'b001:  imm32 = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      3'b010:  imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      3'b011:  imm32 = {ins[31:12], 12'b0};
      3'b100:  imm32 = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm_new = XLEN'($signed(imm32));
`ifdef IMM_GEN_ERR_FLAG_EN
  assign err_new = (bus.imm_src[2:1] == 2'b11);
`endif

  assign bus.in_ready = ~reset & ~sk_valid;
  assign in_fire      = bus.in_valid & bus.in_ready;
  assign out_fire     = or_valid & bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      or_valid <= 1'b0;
      or_imm   <= '0;
      or_fmt   <= '0;
      sk_valid <= 1'b0;
      sk_imm   <= '0;
      sk_fmt   <= '0;
`ifdef IMM_GEN_ERR_FLAG_EN
      or_err   <= 1'b0;
      sk_err   <= 1'b0;
`endif
    end else if (out_fire && sk_valid) begin
      // in_ready is low whenever the skid is full, so no new input competes here
      or_imm   <= sk_imm;
      or_fmt   <= sk_fmt;
      sk_valid <= 1'b0;
`ifdef IMM_GEN_ERR_FLAG_EN
      or_err   <= sk_err;
`endif
    end else if (in_fire && (!or_valid || out_fire)) begin
      or_valid <= 1'b1;
      or_imm   <= imm_new;
      or_fmt   <= bus.imm_src;
`ifdef IMM_GEN_ERR_FLAG_EN
      or_err   <= err_new;
`endif
    end else if (in_fire) begin
      sk_valid <= 1'b1;
      sk_imm   <= imm_new;
      sk_fmt   <= bus.imm_src;
`ifdef IMM_GEN_ERR_FLAG_EN
      sk_err   <= err_new;
`endif
    end else if (out_fire) begin
      or_valid <= 1'b0;
    end
  end

  assign bus.out_valid = or_valid;
  assign bus.imm_ext   = or_imm;
  assign bus.out_fmt   = or_fmt;
`ifdef IMM_GEN_ERR_FLAG_EN
  assign bus.imm_err   = or_err;
`endif
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: directed vectors, backpressure, reset, random traffic vs a queue model.
module tb_imm_gen_pipe;
  localparam int XLEN = 32;
  localparam logic [63:0] MASK = (XLEN == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;

  typedef struct packed {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic clk      = 1'b0;
  logic reset    = 1'b1;

  imm_gen_pipe_if #(.XLEN(XLEN)) bus();
  imm_gen_pipe #(.XLEN(XLEN)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference immediate computed arithmetically from field weights
  function automatic logic [63:0] ref_imm(input logic [31:0] w, input logic [2:0] src);
    longint sw;
    longint r;
    sw = longint'($signed(w));
    case (src)
      3'd0: r = sw >>> 20;
      3'd1: r = (w[31] ? -64'sd4096 : 64'sd0) + longint'(w[7]) * 2048
                + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2;
      3'd2: r = (sw >>> 25) * 32 + longint'(w[11:7]);
      3'd3: r = (sw >>> 12) * 4096;
      3'd4: r = (w[31] ? -64'sd1048576 : 64'sd0) + longint'(w[19:12]) * 4096
                + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2;
      default: r = 0;
    endcase
    return 64'(r) & MASK;
  endfunction

  task automatic step(input logic iv, input logic [31:0] w, input logic [2:0] src, input logic ordy);
    bit did_in;
    bit did_out;
    exp_t e;
    @(negedge clk);
    chk("in_ready", 64'(bus.in_ready), 64'(q.size() < 2));
    chk("out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      chk("imm_ext", 64'(bus.imm_ext), q[0].imm);
      chk("out_fmt", 64'(bus.out_fmt), 64'(q[0].fmt));
`ifdef IMM_GEN_ERR_FLAG_EN
      chk("imm_err", 64'(bus.imm_err), 64'(q[0].err));
`endif
    end
    bus.in_valid  = iv;
    bus.instr     = w;
    bus.imm_src   = src;
    bus.out_ready = ordy;
    did_out = ordy && (q.size() > 0);
    did_in  = iv && (q.size() < 2);
    if (did_out) void'(q.pop_front());
    if (did_in) begin
      e.imm = ref_imm(w, src);
      e.fmt = src;
      e.err = (src >= 3'd6);
      q.push_back(e);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset         = 1'b1;
    bus.in_valid  = 1'($urandom);
    bus.instr     = $urandom;
    bus.imm_src   = 3'($urandom);
    bus.out_ready = 1'($urandom);
    @(negedge clk);
    chk("rst_in_ready_low", 64'(bus.in_ready), 64'd0);
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    q.delete();
    @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_imm_ext", 64'(bus.imm_ext), 64'd0);
    chk("rst_out_fmt", 64'(bus.out_fmt), 64'd0);
    chk("rst_in_ready_high", 64'(bus.in_ready), 64'd1);
`ifdef IMM_GEN_ERR_FLAG_EN
    chk("rst_imm_err", 64'(bus.imm_err), 64'd0);
`endif
  endtask

  // Single word through an empty pipe with out_ready=1; result due one cycle later
  task automatic dir(input string tag, input logic [31:0] w, input logic [2:0] src,
                     input logic [63:0] exp, input logic exp_err);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.instr     = w;
    bus.imm_src   = src;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    chk(tag, 64'(bus.imm_ext), exp & MASK);
    chk({tag, "_fmt"}, 64'(bus.out_fmt), 64'(src));
`ifdef IMM_GEN_ERR_FLAG_EN
    chk({tag, "_err"}, 64'(bus.imm_err), 64'(exp_err));
`else
    if (exp_err) chk({tag, "_zero"}, 64'(bus.imm_ext), 64'd0);
`endif
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.instr     = '0;
    bus.imm_src   = '0;
    bus.out_ready = 1'b0;
    do_reset();

    dir("dir_I", 32'hFFF00093, 3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    dir("dir_B", 32'hFE000EE3, 3'b001, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    dir("dir_U", 32'h800000B7, 3'b011, 64'hFFFF_FFFF_8000_0000, 1'b0);
    dir("dir_J", 32'h0080006F, 3'b100, 64'h0000_0000_0000_0008, 1'b0);
    dir("dir_S", 32'hFE112E23, 3'b010, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    dir("dir_R", 32'hFFFFFFFF, 3'b101, 64'h0, 1'b0);
    dir("dir_undef", 32'hFFF00093, 3'b110, 64'h0, 1'b1);
    dir("dir_after_undef", 32'h00100093, 3'b000, 64'h1, 1'b0);
    step(1'b0, 32'h0, 3'd0, 1'b1);

    // Backpressure: three I words with out_ready low, then drain
    step(1'b1, 32'h00100093, 3'd0, 1'b0);
    step(1'b1, 32'h00200093, 3'd0, 1'b0);
    step(1'b1, 32'h00300093, 3'd0, 1'b0);
    step(1'b1, 32'h00300093, 3'd0, 1'b1);
    step(1'b1, 32'h00300093, 3'd0, 1'b1);
    step(1'b0, 32'h0, 3'd0, 1'b1);
    step(1'b0, 32'h0, 3'd0, 1'b1);

    // Reset with both registers full
    step(1'b1, 32'h00500093, 3'd0, 1'b0);
    step(1'b1, 32'h00600093, 3'd0, 1'b0);
    step(1'b0, 32'h0, 3'd0, 1'b0);
    do_reset();
    step(1'b1, 32'h00700093, 3'd0, 1'b1);
    step(1'b0, 32'h0, 3'd0, 1'b1);
    step(1'b0, 32'h0, 3'd0, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      int ready_pct;
      ready_pct = ((i / 250) % 2 == 0) ? 80 : 30;
      if ($urandom_range(0, 199) == 0) do_reset();
      else step(1'($urandom_range(0, 3) != 0), $urandom, 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 99) < ready_pct));
    end
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 3'd0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
